// File: rtl/mdc_axil_pkg.sv
// Shared response codes and FSM state encodings for the mDC AXI4-Lite register slave.
package mdc_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} wr_state_t;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/mdc_axil_regbank.sv
// Register array for the mDC control/status bank: byte-strobed write port,
// combinational read mux and one-cycle per-register commit pulses.
module mdc_axil_regbank #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         widx_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  input  logic [IDX_W-1:0]         ridx_i,
  output logic [31:0]              rdata_o,
  output logic [NUM_REGS*32-1:0]   reg_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  logic [31:0]         regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_i && (widx_i == IDX_W'(i))) begin
          pulse_q[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) regs_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx_i == IDX_W'(i)) rdata_o = regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_o[32*g +: 32] = regs_q[g];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/mdc_axil_slave_regs.sv
// AXI4-Lite responder for the mDC S00_AXI port: independent write and read FSMs
// in front of the mdc_axil_regbank control/status registers.
module mdc_axil_slave_regs
  import mdc_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]    reg_o,
  output logic [NUM_REGS-1:0]       wr_pulse_o
);

  localparam int          IDX_W = ADDR_WIDTH - 2;
  localparam logic [31:0] NREGS = 32'(NUM_REGS);

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;

  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic                    arready_q, rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    commit_d;
  logic [ADDR_WIDTH-1:0]   caddr_d;
  logic [DATA_WIDTH-1:0]   cdata_d;
  logic [DATA_WIDTH/8-1:0] cstrb_d;
  logic [IDX_W-1:0]        widx, ridx;
  logic                    w_in_range, r_in_range;
  logic [DATA_WIDTH-1:0]   rb_rdata;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID  & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // The commit happens on whichever edge completes the AW/W pair; the missing half
  // comes from the bus, the earlier half from the latches.
  always_comb begin
    commit_d = 1'b0;
    caddr_d  = awaddr_q;
    cdata_d  = wdata_q;
    cstrb_d  = wstrb_q;
    case (wr_state_q)
      W_IDLE: if (aw_hs && w_hs) begin
        commit_d = 1'b1;
        caddr_d  = S_AXI_AWADDR;
        cdata_d  = S_AXI_WDATA;
        cstrb_d  = S_AXI_WSTRB;
      end
      W_WAIT_W: if (w_hs) begin
        commit_d = 1'b1;
        cdata_d  = S_AXI_WDATA;
        cstrb_d  = S_AXI_WSTRB;
      end
      W_WAIT_AW: if (aw_hs) begin
        commit_d = 1'b1;
        caddr_d  = S_AXI_AWADDR;
      end
      default: ;
    endcase
  end

  assign widx       = caddr_d[ADDR_WIDTH-1:2];
  assign w_in_range = (32'(widx) < NREGS);
  assign ridx       = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign r_in_range = (32'(ridx) < NREGS);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (commit_d) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b1;
      bresp_q    <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      wr_state_q <= W_RESP;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awready_q  <= 1'b0;
            wr_state_q <= W_WAIT_W;
          end else if (w_hs) begin
            wready_q   <= 1'b0;
            wr_state_q <= W_WAIT_AW;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Half-transaction holding registers; only meaningful while waiting for the partner.
  always_ff @(posedge ACLK) begin
    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= r_in_range ? rb_rdata : '0;
            rresp_q    <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: if (S_AXI_RREADY) begin
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  mdc_axil_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .we_i       (commit_d & w_in_range),
    .widx_i     (widx),
    .wdata_i    (cdata_d),
    .wstrb_i    (cstrb_d),
    .ridx_i     (ridx),
    .rdata_o    (rb_rdata),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, caddr_d[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_mdc_axil_slave_regs.sv
// Directed bench for mdc_axil_slave_regs with ADDR_WIDTH=5 so both legal and
// out-of-range register indices are reachable.
module tb_mdc_axil_slave_regs;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [4:0]   AWADDR = '0;
  logic [2:0]   AWPROT = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [4:0]   ARADDR = '0;
  logic [2:0]   ARPROT = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [127:0] reg_o;
  logic [3:0]   wr_pulse_o;

  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] exp_regs [4] = '{0, 0, 0, 0};

  mdc_axil_slave_regs #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (AWADDR),
    .S_AXI_AWPROT  (AWPROT),
    .S_AXI_AWVALID (AWVALID),
    .S_AXI_AWREADY (AWREADY),
    .S_AXI_WDATA   (WDATA),
    .S_AXI_WSTRB   (WSTRB),
    .S_AXI_WVALID  (WVALID),
    .S_AXI_WREADY  (WREADY),
    .S_AXI_BRESP   (BRESP),
    .S_AXI_BVALID  (BVALID),
    .S_AXI_BREADY  (BREADY),
    .S_AXI_ARADDR  (ARADDR),
    .S_AXI_ARPROT  (ARPROT),
    .S_AXI_ARVALID (ARVALID),
    .S_AXI_ARREADY (ARREADY),
    .S_AXI_RDATA   (RDATA),
    .S_AXI_RRESP   (RRESP),
    .S_AXI_RVALID  (RVALID),
    .S_AXI_RREADY  (RREADY),
    .reg_o         (reg_o),
    .wr_pulse_o    (wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) if (wr_pulse_o[i] === 1'b1) pulse_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Bus helpers: inputs change and outputs are sampled on the falling edge.
  task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    @(negedge ACLK);
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1;
    for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(negedge ACLK);
      if (aw_f) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_f)  begin WVALID = 1'b0;  w_done = 1;  end
    end
    checks++;
    if (!(aw_done && w_done)) begin
      failures++;
      $display("FAIL aw_w_timeout addr=%h aw_done=%0b w_done=%0b required=1/1", addr, aw_done, w_done);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
  endtask

  task automatic recv_b(output logic [1:0] resp);
    int n = 0;
    while (BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    checks++;
    if (BVALID !== 1'b1) begin failures++; $display("FAIL b_timeout bvalid=%b required=1", BVALID); end
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [4:0] addr);
    int n = 0;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    ARVALID = 1'b0;
    checks++;
    if (n >= 50) begin failures++; $display("FAIL ar_timeout addr=%h arready=%b required=1", addr, ARREADY); end
  endtask

  task automatic recv_r(output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    while (RVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    checks++;
    if (RVALID !== 1'b1) begin failures++; $display("FAIL r_timeout rvalid=%b required=1", RVALID); end
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    send_aw_w(addr, data, strb);
    recv_b(resp);
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    send_ar(addr);
    recv_r(data, resp);
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++; if (AWREADY !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b exp=0", AWREADY); end
    checks++; if (WREADY !== 1'b0)  begin failures++; $display("FAIL reset_wready got=%b exp=0", WREADY); end
    checks++; if (ARREADY !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b exp=0", ARREADY); end
    checks++; if (BVALID !== 1'b0)  begin failures++; $display("FAIL reset_bvalid got=%b exp=0", BVALID); end
    checks++; if (RVALID !== 1'b0)  begin failures++; $display("FAIL reset_rvalid got=%b exp=0", RVALID); end
    checks++; if (BRESP !== 2'b00 || RRESP !== 2'b00) begin
      failures++; $display("FAIL reset_resp bresp=%b rresp=%b exp=00/00", BRESP, RRESP);
    end
    checks++; if (RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", RDATA); end
    checks++; if (reg_o !== 128'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", reg_o); end
    checks++; if (wr_pulse_o !== 4'h0) begin failures++; $display("FAIL reset_pulse got=%b exp=0000", wr_pulse_o); end
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic;
    logic [1:0]  r;
    logic [31:0] d;
    int          base [4];
    for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
    for (int i = 0; i < 4; i++) begin
      do_write(5'(i * 4), 32'(i + 1), 4'hF, r);
      exp_regs[i] = 32'(i + 1);
      checks++; if (r !== 2'b00) begin failures++; $display("FAIL basic_bresp%0d got=%b exp=00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4), d, r);
      checks++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        failures++; $display("FAIL basic_read%0d got=%h/%b exp=%h/00", i, d, r, 32'(i + 1));
      end
    end
    checks++;
    if (reg_o !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      failures++; $display("FAIL basic_reg_o got=%h exp=00000004000000030000000200000001", reg_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pulse_cnt[i] - base[i] != 1) begin
        failures++; $display("FAIL basic_pulse%0d got=%0d exp=1", i, pulse_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_split;
    logic [1:0]  r;
    logic [31:0] d;
    // Address first, data three cycles later.
    @(negedge ACLK);
    AWADDR = 5'h04; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++;
    if ({AWREADY, WREADY} !== 2'b01) begin
      failures++; $display("FAIL split_wait_w_ready got=%b exp=01", {AWREADY, WREADY});
    end
    repeat (2) @(negedge ACLK);
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    checks++; if (BVALID !== 1'b0) begin failures++; $display("FAIL split_early_bvalid got=%b exp=0", BVALID); end
    @(negedge ACLK);
    WVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || wr_pulse_o !== 4'b0010) begin
      failures++; $display("FAIL split_aw_first_commit bvalid=%b pulse=%b exp=1/0010", BVALID, wr_pulse_o);
    end
    recv_b(r);
    exp_regs[1] = 32'hDEADBEEF;
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL split_bresp1 got=%b exp=00", r); end
    // Data first, address three cycles later.
    @(negedge ACLK);
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    checks++;
    if ({AWREADY, WREADY} !== 2'b10) begin
      failures++; $display("FAIL split_wait_aw_ready got=%b exp=10", {AWREADY, WREADY});
    end
    repeat (2) @(negedge ACLK);
    AWADDR = 5'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || wr_pulse_o !== 4'b0100) begin
      failures++; $display("FAIL split_w_first_commit bvalid=%b pulse=%b exp=1/0100", BVALID, wr_pulse_o);
    end
    recv_b(r);
    exp_regs[2] = 32'hCAFEF00D;
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL split_bresp2 got=%b exp=00", r); end
    do_read(5'h04, d, r);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL split_read1 got=%h exp=deadbeef", d); end
    do_read(5'h08, d, r);
    checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL split_read2 got=%h exp=cafef00d", d); end
  endtask

  task automatic test_strobe;
    logic [1:0]  r;
    logic [31:0] d;
    do_write(5'h00, 32'hFFFFFFFF, 4'hF, r);
    do_write(5'h00, 32'h12345678, 4'b0101, r);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL strobe_bresp got=%b exp=00", r); end
    exp_regs[0] = 32'hFF34FF78;
    do_read(5'h00, d, r);
    checks++; if (d !== 32'hFF34FF78) begin failures++; $display("FAIL strobe_read got=%h exp=ff34ff78", d); end
  endtask

  task automatic test_backpressure;
    logic [1:0]  r;
    logic [31:0] d;
    send_aw_w(5'h0C, 32'hA5A55A5A, 4'hF);
    exp_regs[3] = 32'hA5A55A5A;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
        failures++;
        $display("FAIL bp_write_hold%0d bvalid=%b bresp=%b awready=%b wready=%b exp=1/00/0/0",
                 k, BVALID, BRESP, AWREADY, WREADY);
      end
      @(negedge ACLK);
    end
    recv_b(r);
    send_ar(5'h0C);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'hA5A55A5A || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL bp_read_hold%0d rvalid=%b rdata=%h rresp=%b arready=%b exp=1/a5a55a5a/00/0",
                 k, RVALID, RDATA, RRESP, ARREADY);
      end
      @(negedge ACLK);
    end
    recv_r(d, r);
    checks++; if (d !== 32'hA5A55A5A) begin failures++; $display("FAIL bp_read_data got=%h exp=a5a55a5a", d); end
  endtask

  task automatic test_slverr;
    logic [1:0]  r;
    logic [31:0] d;
    int          base;
    base = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    do_write(5'h10, 32'h00000099, 4'hF, r);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL slverr_bresp got=%b exp=10", r); end
    do_read(5'h14, d, r);
    checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      failures++; $display("FAIL slverr_read got=%h/%b exp=00000000/10", d, r);
    end
    checks++;
    if (reg_o !== {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]}) begin
      failures++; $display("FAIL slverr_regs_changed got=%h exp=%h", reg_o,
                           {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]});
    end
    checks++;
    if (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] != base) begin
      failures++; $display("FAIL slverr_pulse got=%0d exp=0",
                           pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - base);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0]  r;
    logic [31:0] d;
    do_write(5'h00, 32'h00000005, 4'hF, r);
    checks++; if (reg_o[31:0] !== 32'h5) begin failures++; $display("FAIL rstmid_pre got=%h exp=5", reg_o[31:0]); end
    @(negedge ACLK);
    AWADDR = 5'h00; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    ARESETN = 1'b0;
    WDATA = 32'hBAD0BAD0; WSTRB = 4'hF; WVALID = 1'b1;
    repeat (2) @(negedge ACLK);
    WVALID = 1'b0;
    ARESETN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (BVALID !== 1'b0 || wr_pulse_o !== 4'h0) begin
        failures++; $display("FAIL rstmid_idle%0d bvalid=%b pulse=%b exp=0/0000", k, BVALID, wr_pulse_o);
      end
      @(negedge ACLK);
    end
    for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4), d, r);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_read%0d got=%h exp=0", i, d); end
    end
    do_write(5'h0C, 32'h00000077, 4'hF, r);
    exp_regs[3] = 32'h77;
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL rstmid_next_bresp got=%b exp=00", r); end
    do_read(5'h0C, d, r);
    checks++; if (d !== 32'h77) begin failures++; $display("FAIL rstmid_next_read got=%h exp=77", d); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  r;
    logic [31:0] d;
    do_write(5'h00, 32'hAAAA0000, 4'hF, r);
    @(negedge ACLK);
    AWADDR = 5'h00; WDATA = 32'h00005555; WSTRB = 4'hF; ARADDR = 5'h00;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++; $display("FAIL b2b_ready got=%b exp=111", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hAAAA0000) begin
      failures++; $display("FAIL b2b_read_old rvalid=%b rdata=%h exp=1/aaaa0000", RVALID, RDATA);
    end
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++; $display("FAIL b2b_bvalid bvalid=%b bresp=%b exp=1/00", BVALID, BRESP);
    end
    recv_r(d, r);
    recv_b(r);
    exp_regs[0] = 32'h00005555;
    do_read(5'h00, d, r);
    checks++; if (d !== 32'h00005555) begin failures++; $display("FAIL b2b_read_new got=%h exp=00005555", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_strobe();
    test_backpressure();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
